// File: rtl/keypad_scan_fifo_if.sv
// CPU register window for keypad_scan_fifo: DATA (addr=0) and STATUS (addr=1).
// rdata is combinational from addr and block state.
interface keypad_scan_fifo_if;
  logic        addr;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (
    output addr, rd_en, wr_en, wdata,
    input  rdata
  );

  modport slave (
    input  addr, rd_en, wr_en, wdata,
    output rdata
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Column-scanned keypad with per-key debounce and a key-code FIFO.
// Define KEYPAD_RELEASE_EN to also queue release codes (DATA[15]=1).
module keypad_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 16000,
  parameter int DEBOUNCE   = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [COLS-1:0]   col_o,
  input  logic [ROWS-1:0]   row_i,
  keypad_scan_fifo_if.slave bus
);
  localparam int NK = ROWS * COLS;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  logic [ROWS-1:0]         s1_q, s2_q, hit;
  logic [CW-1:0]           col_q, col_d;
  logic [DW-1:0]           dwell_q, dwell_d;
  logic [NK-1:0]           db_q, db_d;
  logic [NK-1:0]           pend_q, pend_d;
  logic [NK-1:0]           kind_q, kind_d;
  logic [NK-1:0][BW-1:0]   cnt_q, cnt_d;
  logic [8:0]              mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [NW-1:0]           n_q, n_d;
  logic                    ovf_q, ovf_d;
  logic                    sample, push, pop, flush, ovf_clr;
  logic                    full, empty, wr_mem, kind;
  logic [7:0]              code;
  logic [NK-1:0]           serve;
  logic                    unused;

  assign unused = ^{bus.wdata[15:3], bus.wdata[1]};
  assign hit    = ~s2_q;

  always_comb begin
    sample  = dwell_q == DW'(SCAN_DIV - 1);
    dwell_d = sample ? '0 : dwell_q + 1'b1;
    col_d   = col_q;
    if (sample)
      col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
    col_o         = '1;
    col_o[col_q]  = 1'b0;
  end

  // Lowest pending key index wins, so lower rows go first.
  always_comb begin
    serve = '0;
    code  = '0;
    kind  = 1'b0;
    for (int k = NK - 1; k >= 0; k--)
      if (pend_q[k]) begin
        serve    = '0;
        serve[k] = 1'b1;
        code     = 8'(k);
        kind     = kind_q[k];
      end
    push = |pend_q;
  end

  always_comb begin
    db_d   = db_q;
    cnt_d  = cnt_q;
    pend_d = pend_q & ~serve;
    kind_d = kind_q;
    for (int k = 0; k < NK; k++)
      if (sample && (k % COLS) == int'(col_q)) begin
        if (hit[k / COLS] == db_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] + 1'b1 == BW'(DEBOUNCE)) begin
          cnt_d[k] = '0;
          db_d[k]  = ~db_q[k];
`ifdef KEYPAD_RELEASE_EN
          pend_d[k] = 1'b1;
          kind_d[k] = db_q[k];
`else
          pend_d[k] = ~db_q[k];
          kind_d[k] = 1'b0;
`endif
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
  end

  always_comb begin
    empty   = n_q == '0;
    full    = n_q == NW'(FIFO_DEPTH);
    pop     = bus.rd_en && !bus.addr && !empty;
    flush   = bus.wr_en && bus.addr && bus.wdata[0];
    ovf_clr = bus.wr_en && bus.addr && bus.wdata[2];
    wr_mem  = push && (!full || pop) && !flush;
    wp_d    = wp_q;
    rp_d    = rp_q;
    n_d     = n_q;
    ovf_d   = ovf_q & ~ovf_clr;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
      n_d  = '0;
    end else begin
      if (wr_mem) wp_d = wp_q + 1'b1;
      if (pop)    rp_d = rp_q + 1'b1;
      n_d = n_q + NW'(wr_mem) - NW'(pop);
      if (push && full && !pop) ovf_d = 1'b1;
    end
  end

  always_comb begin
    if (bus.addr)
      bus.rdata = {8'(n_q), 5'b0, ovf_q, full, !empty};
    else if (empty)
      bus.rdata = 16'hFFFF;
    else
      bus.rdata = {mem_q[rp_q][8], 7'b0, mem_q[rp_q][7:0]};
  end

  always_ff @(posedge CLK) begin
    if (wr_mem) mem_q[wp_q] <= {kind, code};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q    <= '1;
      s2_q    <= '1;
      col_q   <= '0;
      dwell_q <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      kind_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= row_i;
      s2_q    <= s1_q;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      kind_q  <= kind_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
    end
  end

  // Serialised edges must drain before the next column sample.
  a_pend_drained: assert property (
    @(posedge CLK) disable iff (!RST)
    !(sample && |(pend_q & ~serve))
  );
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a key-matrix model
// and a scoreboard queue of expected DATA words.
module tb_keypad_scan_fifo;
  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [3:0]       col_o;
  logic [3:0]       row_i;
  logic [3:0][3:0]  keys;
  int               total = 0;
  int               bad = 0;
  logic [15:0]      sb [$];
  logic [15:0]      v;

  keypad_scan_fifo_if bus ();

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4),
    .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .col_o (col_o),
    .row_i (row_i),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    row_i = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic a, output logic [15:0] d);
    @(negedge CLK);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    #1 d = bus.rdata;
    @(negedge CLK);
    bus.rd_en = 1'b0;
  endtask

  task automatic wr(input logic [15:0] d);
    @(negedge CLK);
    bus.addr  = 1'b1;
    bus.wr_en = 1'b1;
    bus.wdata = d;
    @(negedge CLK);
    bus.wr_en = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_col0();
    logic [3:0] prev;
    logic       ok;
    ok = 1'b0;
    @(negedge CLK);
    prev = col_o;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (col_o == 4'b1110 && prev != 4'b1110) ok = 1'b1;
      prev = col_o;
    end
    check("col0_sync", {15'b0, ok}, 16'h0001);
  endtask

  task automatic drain(input string tag);
    logic [15:0] d, e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(1'b0, d);
      check(tag, d, e);
    end
    rd(1'b1, d);
    check({tag, "_status"}, d, 16'h0000);
    rd(1'b0, d);
    check({tag, "_empty"}, d, 16'hFFFF);
  endtask

  initial begin
    keys      = '0;
    bus.addr  = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.wdata = '0;
    cyc(3);
    check("rst_col", {12'b0, col_o}, 16'h000E);
    rd(1'b1, v);
    check("rst_status", v, 16'h0000);
    rd(1'b0, v);
    check("rst_data", v, 16'hFFFF);

    @(negedge CLK);
    RST = 1'b1;
    cyc(3);
    check("rot_hold", {12'b0, col_o}, 16'h000E);
    cyc(1);
    check("rot_c1", {12'b0, col_o}, 16'h000D);
    cyc(4);
    check("rot_c2", {12'b0, col_o}, 16'h000B);
    cyc(4);
    check("rot_c3", {12'b0, col_o}, 16'h0007);
    cyc(4);
    check("rot_wrap", {12'b0, col_o}, 16'h000E);

    // clean press of key 9
    keys[2][1] = 1'b1;
    sb.push_back(16'h0009);
    cyc(80);
    rd(1'b1, v);
    check("press_status", v, 16'h0101);
    rd(1'b0, v);
    check("press_data", v, sb.pop_front());
    rd(1'b1, v);
    check("press_after", v, 16'h0000);
    keys[2][1] = 1'b0;
`ifdef KEYPAD_RELEASE_EN
    sb.push_back(16'h8009);
`endif
    cyc(80);
    drain("rel9");

    // bounce on key 0, one toggle per column-0 sample
    wait_col0();
    keys[0][0] = 1'b1; cyc(16);
    keys[0][0] = 1'b0; cyc(16);
    keys[0][0] = 1'b1; cyc(16);
    keys[0][0] = 1'b0; cyc(16);
    keys[0][0] = 1'b1; cyc(32);
    rd(1'b1, v);
    check("bounce_none", v, 16'h0000);
    cyc(16);
    rd(1'b1, v);
    check("bounce_one", v, 16'h0101);
    sb.push_back(16'h0000);
    drain("bounce");
    keys[0][0] = 1'b0;
`ifdef KEYPAD_RELEASE_EN
    sb.push_back(16'h8000);
`endif
    cyc(80);
    drain("rel0");

    // overflow: five presses into a depth-4 queue
    keys[0][1] = 1'b1; sb.push_back(16'h0001); cyc(80);
    keys[0][2] = 1'b1; sb.push_back(16'h0002); cyc(80);
    keys[0][3] = 1'b1; sb.push_back(16'h0003); cyc(80);
    keys[1][0] = 1'b1; sb.push_back(16'h0004); cyc(80);
    keys[1][1] = 1'b1; cyc(80);
    rd(1'b1, v);
    check("ovf_status", v, 16'h0407);
    wr(16'h0004);
    rd(1'b1, v);
    check("ovf_clear", v, 16'h0403);
    rd(1'b0, v);
    check("ovf_head", v, sb.pop_front());
    rd(1'b1, v);
    check("ovf_pop", v, 16'h0301);
    wr(16'h0001);
    sb.delete();
    rd(1'b1, v);
    check("flush_status", v, 16'h0000);
    rd(1'b0, v);
    check("flush_data", v, 16'hFFFF);
    keys = '0;
    cyc(80);
    wr(16'h0005);
    rd(1'b1, v);
    check("ovf_idle", v, 16'h0000);

    // two rows of column 2 flip together
    keys[0][1] = 1'b1; sb.push_back(16'h0001); cyc(80);
    keys[0][2] = 1'b1; sb.push_back(16'h0002); cyc(80);
    rd(1'b1, v);
    check("sim_pre", v, 16'h0201);
    keys[1][2] = 1'b1;
    keys[3][2] = 1'b1;
    sb.push_back(16'h0006);
    sb.push_back(16'h000E);
    for (int i = 0; i < 100 && v == 16'h0201; i++) begin
      @(negedge CLK);
      bus.addr = 1'b1;
      #1 v = bus.rdata;
    end
    check("sim_first", v, 16'h0301);
    @(negedge CLK);
    #1 v = bus.rdata;
    check("sim_second", v, 16'h0403);

    // key 15 reaches its third sample 48 edges after column 0 starts
    wait_col0();
    keys[3][3] = 1'b1;
    cyc(48);
    bus.addr  = 1'b0;
    bus.rd_en = 1'b1;
    #1 v = bus.rdata;
    check("full_head", v, sb.pop_front());
    sb.push_back(16'h000F);
    @(negedge CLK);
    bus.rd_en = 1'b0;
    bus.addr  = 1'b1;
    #1 v = bus.rdata;
    check("full_pushpop", v, 16'h0403);
    drain("full");
    keys = '0;
    cyc(100);
    wr(16'h0005);
    sb.delete();
    rd(1'b1, v);
    check("sim_idle", v, 16'h0000);

    // press and release key 5
    keys[1][1] = 1'b1;
    sb.push_back(16'h0005);
    cyc(80);
    keys[1][1] = 1'b0;
`ifdef KEYPAD_RELEASE_EN
    sb.push_back(16'h8005);
`endif
    cyc(80);
    drain("rel5");

    // key held through a reset is reported after reset ends
    keys[0][0] = 1'b1;
    cyc(30);
    RST = 1'b0;
    cyc(1);
    check("rst2_col", {12'b0, col_o}, 16'h000E);
    rd(1'b1, v);
    check("rst2_status", v, 16'h0000);
    @(negedge CLK);
    RST = 1'b1;
    cyc(30);
    rd(1'b1, v);
    check("held_early", v, 16'h0000);
    cyc(20);
    rd(1'b1, v);
    check("held_status", v, 16'h0101);
    sb.push_back(16'h0000);
    drain("held");
    keys = '0;
`ifdef KEYPAD_RELEASE_EN
    sb.push_back(16'h8000);
`endif
    cyc(80);
    drain("held_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
